// File: rtl/clock_set_ctrl.sv
// Clock/alarm setting controller: three debounced push-buttons drive a mode
// selector and a Wishbone master that performs BCD read-modify-write updates
// of the time/alarm registers, plus an IRQ-clear write with a sticky timeout flag.
module clock_set_ctrl #(
  parameter int FREQ          = 2000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int WB_ADDR_WIDTH = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn_mode,
  input  logic                     btn_inc,
  input  logic                     btn_ack,
  output logic [WB_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [31:0]              wbm_dat_o,
  input  logic [31:0]              wbm_dat_i,
  output logic [3:0]               wbm_sel_o,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic                     wbm_we_o,
  input  logic                     wbm_ack_i,
  output logic [1:0]               mode_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int DB_RAW = FREQ * DEBOUNCE_MS / 1000;
  localparam int DB     = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int DB_W   = $clog2(DB + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [WB_ADDR_WIDTH-1:0] ADR_ALARM = WB_ADDR_WIDTH'(4'h0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_TIME  = WB_ADDR_WIDTH'(4'h4);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_IRQ   = WB_ADDR_WIDTH'(4'h8);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_MOD, ST_WR} state_t;

  // Button index: 0 = mode, 1 = inc, 2 = ack
  logic [2:0] btn_raw;
  logic [2:0] press;
  assign btn_raw = {btn_ack, btn_inc, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            stable_reg;
      logic            press_reg;
      logic [DB_W-1:0] cnt_reg;

      // Two-flop synchroniser, then accept a level only after DB steady cycles
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          stable_reg <= 1'b0;
          press_reg  <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg != stable_reg) begin
            if (cnt_reg == DB_W'(DB - 1)) begin
              stable_reg <= sync2_reg;
              press_reg  <= sync2_reg;
              cnt_reg    <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  // BCD increment 00..59 with wrap; any invalid digit wraps straight to 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = 8'h00;
    if (v[3:0] > 4'd9 || v[7:4] > 4'd5) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  state_t                   state_reg, state_next;
  logic [1:0]               mode_reg, mode_next;
  logic                     inc_pend_reg, inc_pend_next;
  logic                     ack_pend_reg, ack_pend_next;
  logic [WB_ADDR_WIDTH-1:0] adr_reg, adr_next;
  logic [31:0]              dat_reg, dat_next;
  logic [15:0]              rdata_reg, rdata_next;
  logic                     sec_sel_reg, sec_sel_next;
  logic                     clr_reg, clr_next;
  logic [TO_W-1:0]          wait_reg, wait_next;
  logic                     err_reg, err_next;

  logic unused_dat_hi;
  assign unused_dat_hi = ^wbm_dat_i[31:16];

  // State and datapath registers; reset aborts any bus cycle immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= 2'd0;
      inc_pend_reg <= 1'b0;
      ack_pend_reg <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= 32'h0;
      rdata_reg    <= 16'h0;
      sec_sel_reg  <= 1'b0;
      clr_reg      <= 1'b0;
      wait_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      inc_pend_reg <= inc_pend_next;
      ack_pend_reg <= ack_pend_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      rdata_reg    <= rdata_next;
      sec_sel_reg  <= sec_sel_next;
      clr_reg      <= clr_next;
      wait_reg     <= wait_next;
      err_reg      <= err_next;
    end
  end

  // Next-state, request arbitration (ack before inc) and bus strobes
  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    inc_pend_next = inc_pend_reg;
    ack_pend_next = ack_pend_reg;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    rdata_next    = rdata_reg;
    sec_sel_next  = sec_sel_reg;
    clr_next      = clr_reg;
    wait_next     = wait_reg;
    err_next      = err_reg;
    wbm_cyc_o     = 1'b0;
    wbm_stb_o     = 1'b0;
    wbm_we_o      = 1'b0;
    busy_o        = 1'b0;

    if (press[0]) begin
      mode_next = mode_reg + 2'd1;
    end

    case (state_reg)
      ST_IDLE: begin
        wait_next = '0;
        if (ack_pend_reg) begin
          ack_pend_next = 1'b0;
          clr_next      = 1'b1;
          adr_next      = ADR_IRQ;
          dat_next      = 32'h0;
          state_next    = ST_WR;
        end else if (inc_pend_reg) begin
          inc_pend_next = 1'b0;
          // Field and address are frozen here so later mode steps cannot retarget
          if (mode_reg != 2'd0) begin
            clr_next     = 1'b0;
            adr_next     = (mode_reg == 2'd3) ? ADR_ALARM : ADR_TIME;
            sec_sel_next = (mode_reg == 2'd2);
            state_next   = ST_RD;
          end
        end
      end
      ST_RD: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        busy_o    = 1'b1;
        if (wbm_ack_i) begin
          rdata_next = wbm_dat_i[15:0];
          wait_next  = '0;
          state_next = ST_MOD;
        end else if (wait_reg == TO_W'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          wait_next  = '0;
          state_next = ST_IDLE;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      ST_MOD: begin
        busy_o    = 1'b1;
        wait_next = '0;
        dat_next  = sec_sel_reg ? {16'h0, rdata_reg[15:8], bcd_inc(rdata_reg[7:0])}
                                : {16'h0, bcd_inc(rdata_reg[15:8]), rdata_reg[7:0]};
        state_next = ST_WR;
      end
      ST_WR: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        busy_o    = 1'b1;
        if (wbm_ack_i) begin
          if (clr_reg) begin
            err_next = 1'b0;
          end
          wait_next  = '0;
          state_next = ST_IDLE;
        end else if (wait_reg == TO_W'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          wait_next  = '0;
          state_next = ST_IDLE;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // One pending slot per request; a press on an occupied slot is dropped
    if (press[2]) begin
      ack_pend_next = 1'b1;
    end
    if (press[1] && mode_reg != 2'd0) begin
      inc_pend_next = 1'b1;
    end
  end

  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign wbm_sel_o = 4'b1111;
  assign mode_o    = mode_reg;
  assign err_o     = err_reg;

endmodule
